// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver.
// Ports: clk, RSTn (async low); rx_data/rx_done in; rd_en, ovr_clr in;
//        rd_data (head, 0 when empty), empty, full, count, overrun, irq out.
// Option: UART_RX_FIFO_THRESH_IRQ_EN -> irq on fill level >= IRQ_THRESH.

module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int IRQ_THRESH = 8
) (
    input  logic          clk,
    input  logic          RSTn,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rd_en,
    input  logic          ovr_clr,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          irq
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rx_done_dly_q, rx_done_dly_d;
    logic          overrun_q, overrun_d;
    logic          push, pop, wr_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign overrun = overrun_q;
    assign rd_data = empty ? 8'h00 : mem_q[rptr_q];

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    assign irq = (count_q >= (AW+1)'(IRQ_THRESH)) | overrun_q;
`else
    localparam int unused_irq_thresh = IRQ_THRESH;
    assign irq = ~empty | overrun_q;
`endif

    always_comb begin
        rx_done_dly_d = rx_done;
        push          = rx_done & ~rx_done_dly_q;
        pop           = rd_en & ~empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en         = push & (~full | pop);
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        overrun_d     = overrun_q;
        if (wr_en) wptr_d = wptr_q + AW'(1);
        if (pop)   rptr_d = rptr_q + AW'(1);
        if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !wr_en) count_d = count_q - (AW+1)'(1);
        // set dominates clear
        if (push && !wr_en)     overrun_d = 1'b1;
        else if (ovr_clr)       overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            rx_done_dly_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            rx_done_dly_q <= rx_done_dly_d;
            overrun_q     <= overrun_d;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus, queue scoreboard for popped bytes
// plus direct status checks.

module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rd_en = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overrun, irq;
    logic [4:0] count;

    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    logic [7:0] mon_exp;
    int mcount = 0;

    uart_rx_fifo dut (
        .clk(clk), .RSTn(RSTn), .rx_data(rx_data), .rx_done(rx_done),
        .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count),
        .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    // monitor: every accepted read must present the next expected byte
    always @(negedge clk) begin
        if (RSTn && rd_en && !empty) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rd_pop: got %02h, no byte expected", rd_data);
            end else begin
                mon_exp = q.pop_front();
                if (rd_data !== mon_exp) begin
                    bad++;
                    $display("FAIL rd_pop: got %02h want %02h",
                             rd_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        if (mcount < 16) begin
            q.push_back(b);
            mcount++;
        end
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (mcount > 0) mcount--;
    endtask

    function automatic logic exp_irq(int n, logic ovr);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        return (n >= 8) | ovr;
`else
        return (n != 0) | ovr;
`endif
    endfunction

    initial begin
        // 1: reset state, single byte
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        tick();
        RSTn = 1'b1;
        tick();
        send(8'hA5);
        chk("t1_empty", empty, 0);
        chk("t1_count", count, 1);
        chk("t1_rd_data", rd_data, 8'hA5);
        chk("t1_irq", irq, exp_irq(1, 1'b0));
        pop1();
        chk("t1_empty_after", empty, 1);
        chk("t1_rd_data_after", rd_data, 8'h00);
        chk("t1_irq_after", irq, 0);

        // 2: long rx_done level pushes once
        rx_data = 8'h3C;
        rx_done = 1'b1;
        q.push_back(8'h3C);
        mcount = 1;
        repeat (5) tick();
        rx_done = 1'b0;
        tick();
        chk("t2_count", count, 1);
        pop1();
        chk("t2_count_after", count, 0);

        // 3: fill, overflow, drain, clear
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("t3_full", full, 1);
        chk("t3_count", count, 16);
        send(8'hFF);
        chk("t3_ovr", overrun, 1);
        chk("t3_count_ovr", count, 16);
        chk("t3_irq_ovr", irq, 1);
        for (int i = 0; i < 16; i++) pop1();
        chk("t3_empty", empty, 1);
        chk("t3_ovr_hold", overrun, 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", overrun, 0);

        // 4: push and pop together while full
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        rx_data = 8'h77;
        rx_done = 1'b1;
        rd_en = 1'b1;
        q.push_back(8'h77);
        tick();
        rx_done = 1'b0;
        rd_en = 1'b0;
        tick();
        chk("t4_count", count, 16);
        chk("t4_ovr", overrun, 0);
        rx_data = 8'hEE;
        rx_done = 1'b1;
        ovr_clr = 1'b1;
        tick();
        rx_done = 1'b0;
        ovr_clr = 1'b0;
        tick();
        chk("t4_set_wins", overrun, 1);
        chk("t4_count_drop", count, 16);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        for (int i = 0; i < 16; i++) pop1();
        chk("t4_drained", count, 0);
        chk("t4_q_empty", q.size(), 0);

        // 5: pointer wrap with shallow fill
        for (int i = 0; i < 40; i++) begin
            send(8'h80 + 8'(i));
            chk("t5_count", count, mcount);
            if (mcount >= 3) pop1();
        end
        while (mcount > 0) pop1();
        pop1();
        chk("t5_empty_rd_count", count, 0);
        chk("t5_empty_rd_empty", empty, 1);
        chk("t5_q_empty", q.size(), 0);

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        // 6: threshold irq
        for (int i = 0; i < 7; i++) send(8'hC0 + 8'(i));
        chk("t6_irq7", irq, 0);
        send(8'hC7);
        chk("t6_irq8", irq, 1);
        pop1();
        chk("t6_irq_pop", irq, 0);
`endif

        // mid-stream reset
        send(8'hD0);
        send(8'hD1);
        RSTn = 1'b0;
        #1;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_irq", irq, 0);
        chk("rst_mid_empty", empty, 1);
        q.delete();
        mcount = 0;
        tick();
        RSTn = 1'b1;
        tick();

        // rx_done high across reset release pushes once
        rx_data = 8'h5A;
        rx_done = 1'b1;
        RSTn = 1'b0;
        #1;
        chk("rst_hold_count", count, 0);
        tick();
        RSTn = 1'b1;
        q.push_back(8'h5A);
        mcount = 1;
        repeat (3) tick();
        rx_done = 1'b0;
        tick();
        chk("rst_hold_push", count, 1);
        chk("rst_hold_data", rd_data, 8'h5A);
        pop1();
        chk("rst_hold_q", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
